mult_seq: RTL and testbench

Parametrised sequential shift-add multiplier and the next generation of the team's fixed 32x32 `mult` block. It adds a configurable operand width, a run-time signed/unsigned mode, an optional early-exit path for short multipliers, and an explicit busy flag. It keeps the same enable/done four-phase handshake, so existing controllers drive it unchanged.

---
 rtl/mult_seq.sv | 67 ++++++
 tb/tb_mult_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// mult_seq: parametrised sequential shift-add multiplier with signed mode and optional early exit
module mult_seq #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_multiplicand,
    input  logic [WIDTH-1:0]     data_multiplier,
    input  logic                 ctrl_signed,
    input  logic                 ctrl_enable,
    output logic                 ctrl_busy,
    output logic                 ctrl_done,
    output logic [2*WIDTH-1:0]   data_result
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_nxt;
    logic [WIDTH-1:0] mcand, mplier, mag_a, mag_b, mplier_sh;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0] cnt;
    logic neg, last;
    always_comb begin
        mag_a = (ctrl_signed && data_multiplicand[WIDTH-1]) ? -data_multiplicand : data_multiplicand;
        mag_b = (ctrl_signed && data_multiplier[WIDTH-1]) ? -data_multiplier : data_multiplier;
        mplier_sh = mplier >> 1;
        last = (cnt == CW'(WIDTH-1)) || (EARLY_EXIT && mplier_sh == '0);
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = ctrl_enable ? RUN : IDLE;
            RUN:  state_nxt = last ? FIX : RUN;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = ctrl_enable ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mcand       <= '0;
            mplier      <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            data_result <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: if (ctrl_enable) begin
                    mcand  <= mag_a;
                    mplier <= mag_b;
                    neg    <= ctrl_signed & (data_multiplicand[WIDTH-1] ^ data_multiplier[WIDTH-1]);
                    acc    <= '0;
                    cnt    <= '0;
                end
                RUN: begin
                    if (mplier[0]) acc <= acc + ({{WIDTH{1'b0}}, mcand} << cnt);
                    mplier <= mplier_sh;
                    cnt    <= cnt + 1'b1;
                end
                FIX:  data_result <= neg ? -acc : acc;
                DONE: ;
            endcase
        end
    end
    assign ctrl_busy = (state == RUN) || (state == FIX);
    assign ctrl_done = (state == DONE);
endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: directed checks of mult_seq at WIDTH=32, WIDTH=8 and WIDTH=32 with early exit
module tb_mult_seq;
    logic clk = 1'b0, rst = 1'b1, sg = 1'b0;
    logic [2:0] en = '0, done_v, busy_v;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [63:0] r0, r2;
    logic [15:0] r1;
    int cmp = 0, errs = 0;
    always #5 clk = ~clk;
    mult_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) u0 (.clk(clk), .rst(rst), .data_multiplicand(a32),
        .data_multiplier(b32), .ctrl_signed(sg), .ctrl_enable(en[0]), .ctrl_busy(busy_v[0]),
        .ctrl_done(done_v[0]), .data_result(r0));
    mult_seq #(.WIDTH(8), .EARLY_EXIT(1'b0)) u1 (.clk(clk), .rst(rst), .data_multiplicand(a8),
        .data_multiplier(b8), .ctrl_signed(sg), .ctrl_enable(en[1]), .ctrl_busy(busy_v[1]),
        .ctrl_done(done_v[1]), .data_result(r1));
    mult_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) u2 (.clk(clk), .rst(rst), .data_multiplicand(a32),
        .data_multiplier(b32), .ctrl_signed(sg), .ctrl_enable(en[2]), .ctrl_busy(busy_v[2]),
        .ctrl_done(done_v[2]), .data_result(r2));
    function automatic logic [63:0] res(input int u);
        return (u == 0) ? r0 : (u == 1) ? {48'b0, r1} : r2;
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Start an op on instance u, measure edges to done and busy cycles, then hold and release.
    task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int lat, input int hold, input string tag);
        int n, bc;
        @(negedge clk);
        a32 = a; b32 = b; a8 = a[7:0]; b8 = b[7:0]; sg = s; en[u] = 1'b1;
        @(posedge clk); #1;
        bc = busy_v[u];
        n = 0;
        while (n < 100 && !done_v[u]) begin
            @(posedge clk); #1;
            n++;
            bc += busy_v[u];
        end
        chk({tag, " latency"}, n, lat);
        chk({tag, " busy_cycles"}, bc, lat);
        chk({tag, " result"}, res(u), exp);
        repeat (hold) @(posedge clk);
        #1;
        chk({tag, " done_held"}, done_v[u], 1'b1);
        chk({tag, " result_held"}, res(u), exp);
        @(negedge clk);
        en[u] = 1'b0;
        @(posedge clk); #1;
        chk({tag, " done_fall"}, done_v[u], 1'b0);
    endtask
    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy_v, 3'b000);
        chk("reset done", done_v, 3'b000);
        chk("reset r0", r0, 64'h0);
        chk("reset r1", {48'b0, r1}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 32'd7, 32'd5, 1'b0, 64'd35, 33, 1, "u32 7x5");
        run_op(0, -32'sd7, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFDD, 33, 1, "s32 -7x5");
        run_op(0, -32'sd7, -32'sd5, 1'b1, 64'd35, 33, 5, "s32 -7x-5 hold");
        run_op(1, 32'h80, 32'h80, 1'b1, 64'h4000, 9, 1, "s8 -128x-128");
        run_op(1, 32'h80, 32'h7F, 1'b1, 64'hC080, 9, 1, "s8 -128x127");
        run_op(1, 32'hFF, 32'hFF, 1'b0, 64'hFE01, 9, 1, "u8 255x255");
        run_op(1, 32'h00, 32'hFF, 1'b0, 64'h0, 9, 1, "u8 0x255");
        run_op(2, 32'h1234_5678, 32'd1, 1'b0, 64'h1234_5678, 2, 1, "ee b=1");
        run_op(2, 32'd3, 32'h8000_0000, 1'b0, 64'h1_8000_0000, 33, 1, "ee b=msb");
        run_op(2, 32'd99, 32'd0, 1'b0, 64'h0, 2, 1, "ee b=0");
        run_op(2, -32'sd3, 32'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFEE, 4, 1, "ee -3x6");
        // Enable dropped and operands scrambled mid-RUN: latched values must win.
        @(negedge clk);
        a32 = 32'd100; b32 = 32'd200; sg = 1'b0; en[0] = 1'b1;
        @(posedge clk); #1;
        n = 0;
        repeat (5) begin @(posedge clk); n++; end
        @(negedge clk);
        en[0] = 1'b0; a32 = '1; b32 = '1; sg = 1'b1;
        while (n < 100 && !done_v[0]) begin @(posedge clk); #1; n++; end
        chk("drop latency", n, 33);
        chk("drop result", r0, 64'd20000);
        @(posedge clk); #1;
        chk("drop done_pulse", done_v[0], 1'b0);
        chk("drop no_restart", busy_v[0], 1'b0);
        // Reset at RUN cycle 10 aborts the op and clears the result.
        @(negedge clk);
        a32 = 32'd9; b32 = 32'd9; sg = 1'b0; en[0] = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; en[0] = 1'b0;
        @(posedge clk); #1;
        chk("rst busy", busy_v[0], 1'b0);
        chk("rst done", done_v[0], 1'b0);
        chk("rst result", r0, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 32'd7, 32'd5, 1'b0, 64'd35, 33, 1, "post-rst 7x5");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
